// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: and/or/add/sub/eq/slt/xor in one cycle, optional shift-add multiplier.
// Latency: 1 cycle for single-cycle ops and illegal opcodes; WIDTH+1 cycles for mul.
// Backpressure: the result is held in DONE until out_ready; in_ready is low outside IDLE.
//
// Optional feature macro: ALU_MUL_EN. When it is defined, opcode 3 is an unsigned
// WIDTH x WIDTH -> 2*WIDTH multiply. When it is undefined, opcode 3 is illegal and
// the MUL state, the iteration counter and the multiplicand register are not built.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready    request handshake; request captured when both high
//   alu_control[3:0]       opcode: 0 and, 1 or, 2 add, 3 mul, 4 eq, 6 sub, 7 slt, 8 xor
//   operand_1, operand_2   source operands, WIDTH bits each
//   out_valid / out_ready  result handshake; outputs stable while out_valid && !out_ready
//   result, result_hi      low word; high product word (mul only, otherwise 0)
//   status[7:0]            [7] zero, [6] result_hi!=0, [5] signed ovf, [4] negative,
//                          [3] carry/borrow, [2:1] 0, [0] illegal opcode
module alu_multicycle #(
  parameter int WIDTH     = 32,
  parameter int MUL_CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       status
);

  if (WIDTH < 8 || WIDTH > 64 || (2 ** MUL_CNT_W) < WIDTH) begin : g_param_check
    $error("alu_multicycle: WIDTH must be 8..64 and 2**MUL_CNT_W >= WIDTH");
  end

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_EQ  = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;

`ifdef ALU_MUL_EN
  localparam logic [3:0]           OP_MUL   = 4'd3;
  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  // Low during reset and for the first cycle after release so in_ready
  // rises on the first clock edge after rst_n deasserts.
  logic             init_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [7:0]       status_q;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the live inputs and registered at accept.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] alu_res;
  logic [7:0]       alu_st;
  logic             alu_carry, alu_ovf, alu_illegal;

  assign sum_w = {1'b0, operand_1} + {1'b0, operand_2};
  // Top bit of a zero-extended subtraction is the unsigned borrow (op1 < op2).
  assign dif_w = {1'b0, operand_1} - {1'b0, operand_2};

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (alu_control)
      OP_AND: alu_res = operand_1 & operand_2;
      OP_OR:  alu_res = operand_1 | operand_2;
      OP_XOR: alu_res = operand_1 ^ operand_2;
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (operand_1[WIDTH-1] == operand_2[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = dif_w[WIDTH-1:0];
        alu_carry = dif_w[WIDTH];
        alu_ovf   = (operand_1[WIDTH-1] != operand_2[WIDTH-1]) &&
                    (dif_w[WIDTH-1] != operand_1[WIDTH-1]);
      end
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, operand_1 == operand_2};
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_1) < $signed(operand_2)};
      // Opcode 3 lands here too; with the multiplier built it never uses this path.
      default: alu_illegal = 1'b1;
    endcase
    // An illegal opcode leaves alu_res at zero, so the zero flag gives 8'h81.
    alu_st = {~|alu_res, 1'b0, alu_ovf, alu_res[WIDTH-1], alu_carry, 2'b00, alu_illegal};
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Radix-2 shift-add multiplier. result_hi_q:result_q act as the product
  // accumulator; result_q starts as the multiplier and is shifted out LSB first.
  // ---------------------------------------------------------------------------
  logic                 is_mul;
  logic [WIDTH-1:0]     mcand_q;
  logic [MUL_CNT_W-1:0] cnt_q;
  logic [WIDTH:0]       mul_part;
  logic [2*WIDTH-1:0]   mul_next;
  logic [7:0]           mul_st;

  assign is_mul   = (alu_control == OP_MUL);
  assign mul_part = result_q[0] ? ({1'b0, result_hi_q} + {1'b0, mcand_q})
                                : {1'b0, result_hi_q};
  assign mul_next = {mul_part, result_q[WIDTH-1:1]};
  assign mul_st   = {~|mul_next, |mul_next[2*WIDTH-1:WIDTH], 1'b0,
                     mul_next[WIDTH-1], 4'b0000};
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = init_q;
        if (in_valid && init_q) begin
`ifdef ALU_MUL_EN
          state_d = is_mul ? MUL : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Result registers: written only at accept (and while multiplying), so they
  // hold still for the whole DONE state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      result_hi_q <= '0;
      status_q    <= '0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      cnt_q       <= '0;
`endif
    end else if (accept) begin
      result_q    <= alu_res;
      result_hi_q <= '0;
      status_q    <= alu_st;
`ifdef ALU_MUL_EN
      if (is_mul) begin
        mcand_q  <= operand_1;
        result_q <= operand_2;
        status_q <= '0;
        cnt_q    <= '0;
      end
    end else if (state_q == MUL) begin
      {result_hi_q, result_q} <= mul_next;
      cnt_q                   <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) status_q <= mul_st;
`endif
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign status    = status_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32; mul vectors when ALU_MUL_EN is defined,
// otherwise opcode 3 is expected on the illegal path. Inputs are driven and outputs
// sampled on the falling edge of clk.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic [7:0]  status;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32), .MUL_CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .status      (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current falling edge, measure latency to out_valid,
  // check outputs, optionally stall out_ready for 'hold' cycles, then hand off.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [31:0] exp_hi, input logic [7:0] exp_st,
                        input int hold);
    int lat;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    alu_control = op;
    operand_1   = a;
    operand_2   = b;
    @(negedge clk);
    // Scramble inputs after acceptance; the captured request must not change.
    in_valid    = 1'b0;
    alu_control = op ^ 4'h5;
    operand_1   = ~a;
    operand_2   = ~b;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"},   64'(lat),       64'(exp_lat));
    check({tag, "/result"},    64'(result),    64'(exp_res));
    check({tag, "/result_hi"}, 64'(result_hi), 64'(exp_hi));
    check({tag, "/status"},    64'(status),    64'(exp_st));
    check({tag, "/busy"},      64'(in_ready),  64'd0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "/hold_valid"},  64'(out_valid), 64'd1);
      check({tag, "/hold_ready"},  64'(in_ready),  64'd0);
      check({tag, "/hold_result"}, 64'(result),    64'(exp_res));
      check({tag, "/hold_status"}, 64'(status),    64'(exp_st));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/handoff_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'h0;
    operand_1   = '0;
    operand_2   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/in_ready",  64'(in_ready),  64'd0);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/result",    64'(result),    64'd0);
    check("rst/result_hi", 64'(result_hi), 64'd0);
    check("rst/status",    64'(status),    64'd0);
    rst_n = 1'b1;
    check("rel/in_ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("rel/in_ready_first_edge", 64'(in_ready), 64'd1);

    // Single-cycle operations
    run_op("add_ovf",   4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 32'h0, 8'h30, 0);
    run_op("add_carry", 4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 32'h0, 8'h88, 0);
    run_op("sub_borrow",4'd6, 32'h0000_0000, 32'h0000_0001, 1, 32'hFFFF_FFFF, 32'h0, 8'h18, 0);
    run_op("sub_ovf",   4'd6, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 32'h0, 8'h20, 0);
    run_op("slt_true",  4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 32'h0, 8'h00, 0);
    run_op("slt_false", 4'd7, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h0, 8'h80, 0);
    run_op("and",       4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 32'h0, 8'h10, 0);
    run_op("or",        4'd1, 32'h0F0F_0000, 32'h0000_00F0, 1, 32'h0F0F_00F0, 32'h0, 8'h00, 0);
    run_op("xor",       4'd8, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 32'h5555_5555, 32'h0, 8'h00, 0);

    // Back-to-back eq, second one stalled by out_ready for 10 cycles
    run_op("eq_same",   4'd4, 32'h5, 32'h5, 1, 32'h1, 32'h0, 8'h00, 0);
    run_op("eq_diff",   4'd4, 32'h5, 32'h6, 1, 32'h0, 32'h0, 8'h80, 10);

    // Illegal opcodes
    run_op("ill_5",     4'd5,  32'h1234, 32'h5678, 1, 32'h0, 32'h0, 8'h81, 0);
    run_op("ill_15",    4'd15, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 32'h0, 8'h81, 0);

`ifdef ALU_MUL_EN
    run_op("mul_hi",    4'd3, 32'hFFFF_FFFF, 32'h0000_0002, 33, 32'hFFFF_FFFE, 32'h0000_0001, 8'h50, 0);
    run_op("mul_max",   4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 8'h40, 3);
    run_op("mul_small", 4'd3, 32'h1234_5678, 32'h0000_0009, 33, 32'hA3D7_0A38, 32'h0000_0000, 8'h10, 0);
    run_op("mul_zero",  4'd3, 32'h0000_0000, 32'hDEAD_BEEF, 33, 32'h0000_0000, 32'h0000_0000, 8'h80, 0);
    // Flags and result_hi are cleared by the next non-mul operation
    run_op("add_after_mul", 4'd2, 32'h1, 32'h2, 1, 32'h3, 32'h0, 8'h00, 0);

    // Reset in the middle of a multiply
    check("mulrst/in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_control = 4'd3; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
`else
    // Without the multiplier opcode 3 is illegal
    run_op("mul_off",   4'd3, 32'h3, 32'h4, 1, 32'h0, 32'h0, 8'h81, 0);

    // Reset while a result waits in DONE
    check("donerst/in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_control = 4'd2; operand_1 = 32'h10; operand_2 = 32'h20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("donerst/pending_valid", 64'(out_valid), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", 64'(out_valid), 64'd0);
    check("midrst/in_ready",  64'(in_ready),  64'd0);
    check("midrst/result",    64'(result),    64'd0);
    check("midrst/result_hi", 64'(result_hi), 64'd0);
    check("midrst/status",    64'(status),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst/ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("midrst/ready_first_edge", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    check("midrst/no_result", 64'(seen), 64'd0);

    run_op("ill_after_rst", 4'd5, 32'h3, 32'h4, 1, 32'h0, 32'h0, 8'h81, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 The block SHALL have parameter MUL_CNT_W, default 6, iteration counter width; SHALL satisfy 2**MUL_CNT_W >= WIDTH.
REQ-003 The block SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation request present.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port alu_control, input, 4, opcode: 0 and, 1 or, 2 add, 3 mul, 4 eq, 6 sub, 7 slt, 8 xor; others illegal.
REQ-008 The block SHALL have ports operand_1 and operand_2, input, WIDTH each, source operands.
REQ-009 The block SHALL have port out_valid, output, 1, result and status valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have port result, output, WIDTH, low result word.
REQ-012 The block SHALL have port result_hi, output, WIDTH, upper product word for mul, 0 otherwise.
REQ-013 The block SHALL have port status, output, 8: [7] zero, [6] result_hi nonzero, [5] signed overflow, [4] negative, [3] carry/borrow, [2:1] 0, [0] illegal opcode.

Function
REQ-014 States SHALL be IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Request SHALL be accepted when in_valid && in_ready; opcode and operands SHALL be captured at acceptance, later input changes ignored.
REQ-016 Non-mul opcodes SHALL go IDLE->DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-017 Mul SHALL go IDLE->MUL, perform unsigned radix-2 shift-add over exactly WIDTH cycles, then DONE; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-018 In DONE, result, result_hi, status SHALL hold stable until out_ready=1; on out_valid && out_ready the block SHALL return to IDLE next cycle.
REQ-019 out_valid SHALL be 1 exactly in DONE; a new request SHALL not be accepted in the same cycle as result handoff.
REQ-020 add: result = low WIDTH bits of sum; status[3] = carry out; status[5] = signed overflow.
REQ-021 sub: result = operand_1 - operand_2 mod 2**WIDTH; status[3] = 1 when operand_1 < operand_2 unsigned; status[5] = signed overflow.
REQ-022 eq: result = 1 when operands equal, else 0 (never stale).
REQ-023 slt: result = 1 when operand_1 < operand_2 signed two's complement, else 0.
REQ-024 mul: {result_hi, result} = full 2*WIDTH unsigned product; status[6] = |result_hi.
REQ-025 status[7] SHALL be 1 when {result_hi, result} == 0; status[4] SHALL equal result[WIDTH-1].
REQ-026 Flags SHALL be recomputed per operation, not sticky; flags not defined for an opcode SHALL be 0.
REQ-027 Illegal opcode SHALL take the 1-cycle path with result=0, result_hi=0, status = 8'h81.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, in_ready=0 while asserted, out_valid=0, result=0, result_hi=0, status=0, counter=0.
REQ-029 Reset during MUL or DONE SHALL abandon the operation; no result SHALL be presented after release.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-031 With macro ALU_MUL_EN defined, mul SHALL behave per REQ-017 and REQ-024.
REQ-032 Without ALU_MUL_EN, MUL state and multiplier datapath SHALL be absent, opcode 3 SHALL be treated as illegal per REQ-027.

Verification (WIDTH=32, ALU_MUL_EN defined)
REQ-033 add 32'h7FFFFFFF + 32'h1, out_ready=1 -> out_valid 1 cycle after accept, result 32'h80000000, status 8'h30.
REQ-034 sub 32'h0 - 32'h1 -> result 32'hFFFFFFFF, status 8'h18; slt 32'hFFFFFFFF,32'h1 -> result 1, status 8'h00.
REQ-035 mul 32'hFFFFFFFF * 32'h2 -> out_valid exactly 33 cycles after accept, result 32'hFFFFFFFE, result_hi 32'h1, status 8'h50.
REQ-036 eq 5,5 then eq 5,6 back to back -> results 1 then 0; out_ready held 0 for 10 cycles -> outputs stable, in_ready 0.
REQ-037 rst_n pulsed low at cycle 10 of a mul -> out_valid never asserts for it; in_ready 1 first edge after release; opcode 5 -> status 8'h81.
REQ-038 Rebuild without ALU_MUL_EN: opcode 3 with 3,4 -> latency 1, result 0, status 8'h81.
